// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack.
// Next-PC priority: return > call > jump > taken conditional jump > sequential.
module pc_stack_unit #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [PC_W-1:0]          target,
    input  logic                     jump,
    input  logic                     c_jump,
    input  logic                     cond,
    input  logic                     stack_up,
    input  logic                     stack_down,
    input  logic                     c_stack,
    output logic [PC_W-1:0]          pc,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     stk_ovf,
    output logic                     stk_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] stack_mem [DEPTH];
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] stack_top;
    logic [AW-1:0]   top_idx;
    logic [DW-1:0]   depth_next;
    logic            do_ret;
    logic            push;
    logic            ovf_set;
    logic            unf_set;

    assign full      = (depth == DW'(DEPTH));
    assign empty     = (depth == '0);
    assign pc_inc    = pc + 1'b1;
    assign do_ret    = stack_down & c_stack;
    // When empty this index wraps, but the value is never selected.
    assign top_idx   = depth[AW-1:0] - 1'b1;
    assign stack_top = stack_mem[top_idx];

    always_comb begin
        pc_next    = pc_inc;
        depth_next = depth;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (do_ret) begin
            if (!empty) begin
                pc_next    = stack_top;
                depth_next = depth - 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end else if (stack_up) begin
            pc_next = target;
            if (!full) begin
                push       = 1'b1;
                depth_next = depth + 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (jump || (c_jump && cond)) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            depth   <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (en) begin
            pc      <= pc_next;
            depth   <= depth_next;
            stk_ovf <= stk_ovf | ovf_set;
            stk_unf <= stk_unf | unf_set;
        end
    end

    // Storage is not reset; entries above depth are never read onto pc.
    always_ff @(posedge clk) begin
        if (rst_n && en && push) begin
            stack_mem[depth[AW-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit (PC_W=8, DEPTH=8).
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       rst_n, en, jump, c_jump, cond, stack_up, stack_down, c_stack;
    logic [7:0] target;
    logic [7:0] pc;
    logic [3:0] depth;
    logic       full, empty, stk_ovf, stk_unf;
    int         n_checks = 0;
    int         n_fail   = 0;

    pc_stack_unit #(.PC_W(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .target(target), .jump(jump),
        .c_jump(c_jump), .cond(cond), .stack_up(stack_up),
        .stack_down(stack_down), .c_stack(c_stack), .pc(pc), .depth(depth),
        .full(full), .empty(empty), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic clear_req();
        jump = 0; c_jump = 0; cond = 0; stack_up = 0;
        stack_down = 0; c_stack = 0; target = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic do_reset();
        clear_req();
        en = 1; rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic jump_to(input logic [7:0] a);
        jump = 1; target = a;
        step();
    endtask

    task automatic test_reset();
        stack_up = 1; target = 8'h55; en = 1; rst_n = 0;
        step();
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want 00", pc); end
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_depth: got %0d want 0", depth); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
        n_checks++; if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sticky: ovf=%b unf=%b want 0/0", stk_ovf, stk_unf); end
        rst_n = 1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (pc !== 8'(i)) begin n_fail++; $display("[TB] FAIL seq_pc%0d: got %h want %h", i, pc, 8'(i)); end
        end
        n_checks++; if (depth !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_depth: depth=%0d empty=%b want 0/1", depth, empty); end
    endtask

    task automatic test_call_return();
        step();
        n_checks++; if (pc !== 8'h05) begin n_fail++; $display("[TB] FAIL pre_call_pc: got %h want 05", pc); end
        stack_up = 1; target = 8'h40;
        step();
        n_checks++; if (pc !== 8'h40 || depth !== 4'd1) begin n_fail++; $display("[TB] FAIL call: pc=%h depth=%0d want 40/1", pc, depth); end
        stack_down = 1; c_stack = 0;
        step();
        n_checks++; if (pc !== 8'h41 || depth !== 4'd1) begin n_fail++; $display("[TB] FAIL down_no_cstack: pc=%h depth=%0d want 41/1", pc, depth); end
        stack_down = 1; c_stack = 1;
        step();
        n_checks++; if (pc !== 8'h06 || depth !== 4'd0) begin n_fail++; $display("[TB] FAIL return: pc=%h depth=%0d want 06/0", pc, depth); end
    endtask

    task automatic test_overflow_unwind();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            stack_up = 1; target = 8'(k * 16);
            step();
            n_checks++; if (pc !== 8'(k * 16) || depth !== 4'(k) || full !== (k == 8)) begin
                n_fail++; $display("[TB] FAIL call%0d: pc=%h depth=%0d full=%b want %h/%0d/%b", k, pc, depth, full, 8'(k * 16), k, (k == 8));
            end
        end
        stack_up = 1; target = 8'h90;
        step();
        n_checks++; if (pc !== 8'h90 || depth !== 4'd8 || stk_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_call: pc=%h depth=%0d ovf=%b want 90/8/1", pc, depth, stk_ovf); end
        for (int k = 8; k >= 1; k--) begin
            stack_down = 1; c_stack = 1;
            step();
            n_checks++; if (pc !== 8'((k - 1) * 16 + 1) || depth !== 4'(k - 1)) begin
                n_fail++; $display("[TB] FAIL unwind%0d: pc=%h depth=%0d want %h/%0d", k, pc, depth, 8'((k - 1) * 16 + 1), k - 1);
            end
        end
        n_checks++; if (stk_ovf !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: ovf=%b empty=%b want 1/1", stk_ovf, empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        jump_to(8'h10);
        stack_down = 1; c_stack = 1;
        step();
        n_checks++; if (pc !== 8'h11 || depth !== 4'd0 || stk_unf !== 1'b1) begin n_fail++; $display("[TB] FAIL underflow: pc=%h depth=%0d unf=%b want 11/0/1", pc, depth, stk_unf); end
        step();
        n_checks++; if (pc !== 8'h12 || stk_unf !== 1'b1 || stk_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL unf_sticky: pc=%h unf=%b ovf=%b want 12/1/0", pc, stk_unf, stk_ovf); end
    endtask

    task automatic test_cjump_wrap();
        do_reset();
        jump_to(8'h03);
        c_jump = 1; cond = 0; target = 8'h20;
        step();
        n_checks++; if (pc !== 8'h04) begin n_fail++; $display("[TB] FAIL cjump_not_taken: got %h want 04", pc); end
        c_jump = 1; cond = 1; target = 8'h20;
        step();
        n_checks++; if (pc !== 8'h20) begin n_fail++; $display("[TB] FAIL cjump_taken: got %h want 20", pc); end
        en = 0; jump = 1; target = 8'h99;
        step();
        en = 1;
        n_checks++; if (pc !== 8'h20) begin n_fail++; $display("[TB] FAIL stall_pc: got %h want 20", pc); end
        jump_to(8'hFF);
        step();
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap: got %h want 00", pc); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        jump_to(8'h06);
        stack_up = 1; target = 8'h50;
        step();
        en = 0; stack_down = 1; c_stack = 1;
        step();
        en = 1;
        n_checks++; if (pc !== 8'h50 || depth !== 4'd1) begin n_fail++; $display("[TB] FAIL stall_return: pc=%h depth=%0d want 50/1", pc, depth); end
        stack_down = 1; c_stack = 1; stack_up = 1; target = 8'h30;
        step();
        n_checks++; if (pc !== 8'h07 || depth !== 4'd0 || stk_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ret_vs_call: pc=%h depth=%0d ovf=%b want 07/0/0", pc, depth, stk_ovf); end
    endtask

    task automatic test_reset_mid();
        jump_to(8'h20);
        stack_up = 1; target = 8'h70;
        step();
        stack_down = 1; c_stack = 1; rst_n = 0;
        step();
        rst_n = 1;
        n_checks++; if (pc !== 8'h00 || depth !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_mid: pc=%h depth=%0d want 00/0", pc, depth); end
        step();
        n_checks++; if (pc !== 8'h01 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL after_reset: pc=%h empty=%b want 01/1", pc, empty); end
    endtask

    initial begin
        clear_req();
        rst_n = 0; en = 0;
        test_reset();
        test_sequential();
        test_call_return();
        test_overflow_unwind();
        test_underflow();
        test_cjump_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter: PC_W, default 8, program-counter and return-address width.
REQ-002 Parameter: DEPTH, default 8, number of return-stack entries (power of two, >=2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port: en  input  1  advance enable; 0 = stall, all state held.
REQ-006 Port: target  input  PC_W  jump/call destination address from the instruction word.
REQ-007 Port: jump  input  1  unconditional jump request from decoder.
REQ-008 Port: c_jump  input  1  conditional-jump request from decoder.
REQ-009 Port: cond  input  1  branch condition from flags; used only with c_jump.
REQ-010 Port: stack_up  input  1  call request: push return address, go to target.
REQ-011 Port: stack_down  input  1  return request: pop.
REQ-012 Port: c_stack  input  1  selects stack top as next PC; a return is taken only when stack_down and c_stack are both 1.
REQ-013 Port: pc  output  PC_W  current program counter, registered.
REQ-014 Port: depth  output  clog2(DEPTH)+1  number of valid stack entries, registered.
REQ-015 Port: full / empty  output  1 each  depth==DEPTH / depth==0, decoded from the depth register.
REQ-016 Port: stk_ovf / stk_unf  output  1 each  sticky overflow / underflow flags, registered.

Function
REQ-017 en=0 SHALL hold pc, depth, stack contents and flags unchanged regardless of other inputs.
REQ-018 With en=1 the next pc SHALL be selected by fixed priority: return > call > jump > (c_jump & cond) > pc+1.
REQ-019 Return (stack_down & c_stack, not empty): pc <= stack top; depth decrements by 1; takes effect on the next edge (1-cycle latency).
REQ-020 Call (stack_up): pc <= target; pc+1 pushed at index depth; depth increments by 1.
REQ-021 Jump: pc <= target; the stack is untouched.
REQ-022 Conditional jump: pc <= target when cond=1, else pc+1.
REQ-023 Sequential advance and the pushed return address SHALL be computed modulo 2^PC_W (pc = 2^PC_W-1 wraps to 0).
REQ-024 Call when full: pc <= target, push discarded, depth unchanged, stk_ovf <= 1.
REQ-025 Return when empty: pc <= pc+1, depth unchanged (stays 0), stk_unf <= 1.
REQ-026 stack_down without c_stack SHALL be treated as no stack operation; normal priority applies.
REQ-027 Simultaneous return and call: return wins; no push occurs; stk_ovf not set by the ignored call.
REQ-028 stk_ovf/stk_unf SHALL remain 1 until reset; they do not affect normal operation.
REQ-029 The stack top used by a return SHALL be entry depth-1, read combinationally from storage in the same cycle.
REQ-030 Stack storage SHALL be DEPTH x PC_W registers; entries at index >= depth are don't-care and never observable on pc.

Reset
REQ-031 rst_n=0 at a rising edge SHALL set pc=0, depth=0, stk_ovf=0, stk_unf=0; full=0, empty=1 follow.
REQ-032 Reset SHALL override en and all requests; stack contents need not be cleared.
REQ-033 Reset asserted mid-call/return SHALL discard the operation; first cycle after release begins from pc=0, depth=0.

Verification
REQ-034 Reset, then 4 cycles en=1 with no requests -> pc 0,1,2,3,4; depth=0; empty=1.
REQ-035 At pc=5: call target=0x40 -> pc=0x40, depth=1; later return (stack_down=c_stack=1) -> pc=0x06, depth=0.
REQ-036 DEPTH=8: 9 nested calls -> depth=8, full=1 after 8th; 9th call sets pc=target, stk_ovf=1, depth stays 8; 8 returns unwind in reverse order to the correct addresses.
REQ-037 Return with depth=0 at pc=0x10 -> pc=0x11, stk_unf=1, depth=0.
REQ-038 c_jump=1 target=0x20: cond=0 at pc=3 -> pc=4; cond=1 -> pc=0x20; en=0 cycle -> pc held; pc=0xFF with no request -> pc=0x00.
REQ-039 Simultaneous return (depth=1, top=0x07) and call target=0x30 -> pc=0x07, depth=0, stk_ovf=0.
